// File: rtl/sdram_burst_write.sv
// SDRAM single-burst write engine: ACTIVE, WRITE plus burst data, then PRECHARGE, with tRCD/tWR/tRP timing.
// Optional macro SDRAM_WR_AUTO_PRECHARGE_EN: the WRITE sets A10 and the PRECHARGE slot becomes a NOP.
module sdram_burst_write #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BA_W      = 2,
   parameter int unsigned ROW_W     = 11,
   parameter int unsigned COL_W     = 8,
   parameter int unsigned ADDR_W    = 11,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned T_RCD     = 3,
   parameter int unsigned T_WR      = 2,
   parameter int unsigned T_RP      = 3
) (
   input  logic                  sclk,
   input  logic                  srst,
   input  logic                  wr_req,
   output logic                  wr_ack,
   output logic                  wr_done,
   input  logic [BA_W-1:0]       i_wr_ba,
   input  logic [ROW_W-1:0]      i_wr_row,
   input  logic [COL_W-1:0]      i_wr_col,
   output logic                  o_wr_data_req,
   input  logic [DATA_W-1:0]     i_wr_data,
   output logic [ADDR_W-1:0]     o_wr_addr,
   output logic [BA_W-1:0]       o_wr_ba,
   output logic [DATA_W-1:0]     o_wr_data,
   output logic                  o_wr_oe_n,
   output logic [DATA_W/8-1:0]   o_wr_dqm,
   output logic                  o_wr_cs_n,
   output logic                  o_wr_ras_n,
   output logic                  o_wr_cas_n,
   output logic                  o_wr_we_n
);

   localparam int unsigned DQM_W   = DATA_W / 8;
   localparam int unsigned MAX_A   = (T_RCD > T_WR) ? T_RCD : T_WR;
   localparam int unsigned MAX_B   = (T_RP > BURST_LEN) ? T_RP : BURST_LEN;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [3:0] CMD_DESEL = 4'b1111;
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_WR    = 4'b0100;
   localparam logic [3:0] CMD_PRE   = 4'b0010;

`ifdef SDRAM_WR_AUTO_PRECHARGE_EN
   localparam logic AUTO_PRE = 1'b1;
`else
   localparam logic AUTO_PRE = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_ACT, S_TRCD, S_WR, S_BURST, S_TWR, S_PRE, S_TRP
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BA_W-1:0]      ba_l_q, ba_l_d;
   logic [ROW_W-1:0]     row_l_q, row_l_d;
   logic [COL_W-1:0]     col_l_q, col_l_d;
   logic [3:0]           cmd_q, cmd_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [BA_W-1:0]      ba_q, ba_d;
   logic                 dreq_q, dreq_d;
   logic                 oe_n_q, oe_n_d;
   logic [DQM_W-1:0]     dqm_q, dqm_d;
   logic                 ack_q, ack_d;
   logic                 done_q, done_d;
   logic [COL_W-1:0]     col_aligned;
   logic [ADDR_W-1:0]    col_addr;

   // Next state, counter reload on every state entry, and request latching
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ba_l_d  = ba_l_q;
      row_l_d = row_l_q;
      col_l_d = col_l_q;
      case (state_q)
         S_IDLE: if (wr_req) begin
            ba_l_d  = i_wr_ba;
            row_l_d = i_wr_row;
            col_l_d = i_wr_col;
            state_d = S_ACT;
         end
         S_ACT: begin
            state_d = S_TRCD;
            cnt_d   = CNT_W'(T_RCD - 2);
         end
         S_TRCD: if (cnt_q == '0) state_d = S_WR; else cnt_d = cnt_q - CNT_W'(1);
         S_WR: begin
            if (BURST_LEN > 1) begin
               state_d = S_BURST;
               cnt_d   = CNT_W'(BURST_LEN - 2);
            end else begin
               state_d = S_TWR;
               cnt_d   = CNT_W'(T_WR - 1);
            end
         end
         S_BURST: begin
            if (cnt_q == '0) begin
               state_d = S_TWR;
               cnt_d   = CNT_W'(T_WR - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_TWR: if (cnt_q == '0) state_d = S_PRE; else cnt_d = cnt_q - CNT_W'(1);
         S_PRE: begin
            state_d = S_TRP;
            cnt_d   = CNT_W'(T_RP - 2);
         end
         S_TRP: if (cnt_q == '0) state_d = S_IDLE; else cnt_d = cnt_q - CNT_W'(1);
         default: state_d = S_IDLE;
      endcase
   end

   // Burst-aligned start column so the burst never wraps within the row
   always_comb begin
      col_aligned  = col_l_d & ~COL_W'(BURST_LEN - 1);
      col_addr     = ADDR_W'(col_aligned);
      col_addr[10] = AUTO_PRE;
   end

   // Pin values decoded from the upcoming state so they register in step with it
   always_comb begin
      cmd_d  = CMD_DESEL;
      addr_d = '0;
      ba_d   = '0;
      dreq_d = 1'b0;
      oe_n_d = 1'b1;
      dqm_d  = '1;
      ack_d  = 1'b0;
      done_d = (state_q == S_TRP) && (state_d == S_IDLE);
      if (state_d != S_IDLE) ba_d = ba_l_d;
      case (state_d)
         S_ACT: begin
            cmd_d  = CMD_ACT;
            addr_d = ADDR_W'(row_l_d);
            ack_d  = 1'b1;
         end
         S_WR: begin
            cmd_d  = CMD_WR;
            addr_d = col_addr;
         end
         S_PRE:   cmd_d = AUTO_PRE ? CMD_NOP : CMD_PRE;
         S_TRCD, S_BURST, S_TWR, S_TRP: cmd_d = CMD_NOP;
         default: cmd_d = CMD_DESEL;
      endcase
      if (state_d == S_WR || state_d == S_BURST) begin
         dreq_d = 1'b1;
         oe_n_d = 1'b0;
         dqm_d  = '0;
      end
   end

   always_ff @(posedge sclk or posedge srst) begin
      if (srst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ba_l_q  <= '0;
         row_l_q <= '0;
         col_l_q <= '0;
         cmd_q   <= CMD_DESEL;
         addr_q  <= '0;
         ba_q    <= '0;
         dreq_q  <= 1'b0;
         oe_n_q  <= 1'b1;
         dqm_q   <= '1;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ba_l_q  <= ba_l_d;
         row_l_q <= row_l_d;
         col_l_q <= col_l_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         ba_q    <= ba_d;
         dreq_q  <= dreq_d;
         oe_n_q  <= oe_n_d;
         dqm_q   <= dqm_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   // Show-ahead FIFO word goes straight to DQ in the strobe cycle
   assign o_wr_data = dreq_q ? i_wr_data : '0;
   assign {o_wr_cs_n, o_wr_ras_n, o_wr_cas_n, o_wr_we_n} = cmd_q;
   assign o_wr_addr     = addr_q;
   assign o_wr_ba       = ba_q;
   assign o_wr_oe_n     = oe_n_q;
   assign o_wr_dqm      = dqm_q;
   assign o_wr_data_req = dreq_q;
   assign wr_ack        = ack_q;
   assign wr_done       = done_q;

endmodule

// File: tb/tb_sdram_burst_write.sv
// Scoreboard bench for sdram_burst_write: randomized requests against a cycle-stamped expected pin trace.
module tb_sdram_burst_write;

   localparam int BL   = 4;
   localparam int TRCD = 3;
   localparam int TWR  = 2;
   localparam int TRP  = 3;
`ifdef SDRAM_WR_AUTO_PRECHARGE_EN
   localparam bit AP = 1'b1;
`else
   localparam bit AP = 1'b0;
`endif

   logic        sclk, srst, wr_req, wr_ack, wr_done;
   logic [1:0]  i_wr_ba;
   logic [10:0] i_wr_row;
   logic [7:0]  i_wr_col;
   logic        o_wr_data_req;
   logic [31:0] i_wr_data;
   logic [10:0] o_wr_addr;
   logic [1:0]  o_wr_ba;
   logic [31:0] o_wr_data;
   logic        o_wr_oe_n;
   logic [3:0]  o_wr_dqm;
   logic        o_wr_cs_n, o_wr_ras_n, o_wr_cas_n, o_wr_we_n;

   sdram_burst_write dut (
      .sclk(sclk), .srst(srst), .wr_req(wr_req), .wr_ack(wr_ack), .wr_done(wr_done),
      .i_wr_ba(i_wr_ba), .i_wr_row(i_wr_row), .i_wr_col(i_wr_col),
      .o_wr_data_req(o_wr_data_req), .i_wr_data(i_wr_data),
      .o_wr_addr(o_wr_addr), .o_wr_ba(o_wr_ba), .o_wr_data(o_wr_data),
      .o_wr_oe_n(o_wr_oe_n), .o_wr_dqm(o_wr_dqm),
      .o_wr_cs_n(o_wr_cs_n), .o_wr_ras_n(o_wr_ras_n), .o_wr_cas_n(o_wr_cas_n), .o_wr_we_n(o_wr_we_n)
   );

   typedef struct {
      int          cyc;
      logic [3:0]  cmd;
      logic [10:0] addr;
      logic [1:0]  ba;
      logic        dreq;
      logic [31:0] data;
      logic        ack;
      logic        done;
   } rec_t;

   rec_t        exq[$];
   logic [31:0] fq[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          free  = 0;
   logic [31:0] wdata = '0;

   assign i_wr_data = wdata;

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   always @(posedge sclk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endfunction

   function automatic logic [3:0] cmd_now();
      return {o_wr_cs_n, o_wr_ras_n, o_wr_cas_n, o_wr_we_n};
   endfunction

   // Monitor: every cycle with a selected chip or a handshake pulse consumes one expected record
   always @(negedge sclk) begin
      if (!srst) begin
         if (!o_wr_cs_n || wr_done || wr_ack || o_wr_data_req) begin
            if (exq.size() == 0) begin
               chk("unexpected_output", 64'(exq.size()), 64'd1);
            end else begin
               rec_t r;
               r = exq.pop_front();
               chk("cycle", 64'(cyc), 64'(r.cyc));
               chk("cmd", 64'(cmd_now()), 64'(r.cmd));
               chk("addr", 64'(o_wr_addr), 64'(r.addr));
               chk("ba", 64'(o_wr_ba), 64'(r.ba));
               chk("ack", 64'(wr_ack), 64'(r.ack));
               chk("done", 64'(wr_done), 64'(r.done));
               chk("data_req", 64'(o_wr_data_req), 64'(r.dreq));
               chk("oe_n", 64'(o_wr_oe_n), 64'(!r.dreq));
               chk("dqm", 64'(o_wr_dqm), r.dreq ? 64'h0 : 64'hF);
               chk("dq", 64'(o_wr_data), r.dreq ? 64'(r.data) : 64'h0);
            end
         end
         if (o_wr_data_req && fq.size() > 0) void'(fq.pop_front());
         wdata = (fq.size() > 0) ? fq[0] : 32'h0;
      end
   end

   // Reference: the whole pin trace of one request follows from its accept cycle and the timing rules
   task automatic do_req(input logic [1:0] ba, input logic [10:0] row, input logic [7:0] col,
                         input bit fixed, output int acc);
      int          t_wr, t_last, t_pre, t_done;
      logic [31:0] w[BL];
      wr_req   = 1'b1;
      i_wr_ba  = ba;
      i_wr_row = row;
      i_wr_col = col;
      acc    = (cyc > free) ? cyc : free;
      t_wr   = acc + TRCD + 1;
      t_last = t_wr + BL - 1;
      t_pre  = t_last + TWR + 1;
      t_done = t_pre + TRP;
      for (int i = 0; i < BL; i++) begin
         w[i] = fixed ? (32'hD0D0_0000 + 32'(i)) : $urandom;
         fq.push_back(w[i]);
      end
      for (int k = acc + 1; k <= t_done; k++) begin
         rec_t r;
         r.cyc = k; r.cmd = 4'b0111; r.addr = '0; r.ba = ba;
         r.dreq = 1'b0; r.data = '0; r.ack = 1'b0; r.done = 1'b0;
         if (k == acc + 1) begin
            r.cmd = 4'b0011; r.addr = row; r.ack = 1'b1;
         end
         if (k == t_wr) begin
            r.cmd  = 4'b0100;
            r.addr = 11'((int'(col) / BL) * BL) | (AP ? 11'h400 : 11'h0);
         end
         if (k >= t_wr && k <= t_last) begin
            r.dreq = 1'b1; r.data = w[k - t_wr];
         end
         if (k == t_pre) r.cmd = AP ? 4'b0111 : 4'b0010;
         if (k == t_done) begin
            r.cmd = 4'b1111; r.ba = '0; r.done = 1'b1;
         end
         exq.push_back(r);
      end
      free = t_done;
      while (cyc < acc + 1) @(negedge sclk);
   endtask

   task automatic spur_pulse(input int acc);
      while (cyc < acc + 5) @(negedge sclk);
      if (acc + 6 < free) begin
         wr_req   = 1'b1;
         i_wr_ba  = 2'($urandom);
         i_wr_row = 11'($urandom);
         i_wr_col = 8'($urandom);
         @(negedge sclk);
         wr_req = 1'b0;
      end
   endtask

   initial begin
      int  acc;
      bit  b2b;
      srst = 1'b1; wr_req = 1'b0; i_wr_ba = '0; i_wr_row = '0; i_wr_col = '0;
      @(negedge sclk);
      chk("rst_cmd", 64'(cmd_now()), 64'hF);
      chk("rst_addr", 64'(o_wr_addr), 64'h0);
      chk("rst_ba", 64'(o_wr_ba), 64'h0);
      chk("rst_dq", 64'(o_wr_data), 64'h0);
      chk("rst_oe_n", 64'(o_wr_oe_n), 64'h1);
      chk("rst_dqm", 64'(o_wr_dqm), 64'hF);
      chk("rst_ack", 64'(wr_ack), 64'h0);
      chk("rst_done", 64'(wr_done), 64'h0);
      chk("rst_dreq", 64'(o_wr_data_req), 64'h0);
      @(negedge sclk);
      srst = 1'b0;
      free = cyc;

      // Directed burst with a stray request pulse in the middle of the data phase
      do_req(2'd2, 11'h155, 8'h23, 1'b1, acc);
      wr_req = 1'b0;
      spur_pulse(acc);

      // Randomized traffic: gaps, back-to-back held requests and stray pulses
      b2b = 1'b0;
      for (int n = 0; n < 24; n++) begin
         if (!b2b) repeat ($urandom_range(0, 4)) @(negedge sclk);
         do_req(2'($urandom), 11'($urandom), 8'($urandom), 1'b0, acc);
         b2b = ($urandom_range(0, 2) == 0);
         if (!b2b) begin
            wr_req = 1'b0;
            if ($urandom_range(0, 1) == 1) spur_pulse(acc);
         end
      end
      wr_req = 1'b0;
      while (cyc < free + 1) @(negedge sclk);

      // Asynchronous reset in the middle of a burst abandons it without a done pulse
      do_req(2'd1, 11'h2AA, 8'h17, 1'b0, acc);
      wr_req = 1'b0;
      while (cyc < acc + 5) @(negedge sclk);
      srst = 1'b1;
      #1;
      chk("arst_cmd", 64'(cmd_now()), 64'hF);
      chk("arst_oe_n", 64'(o_wr_oe_n), 64'h1);
      chk("arst_dreq", 64'(o_wr_data_req), 64'h0);
      exq.delete();
      fq.delete();
      repeat (2) begin
         @(negedge sclk);
         chk("arst_no_done", 64'(wr_done), 64'h0);
         chk("arst_hold_cmd", 64'(cmd_now()), 64'hF);
      end
      srst = 1'b0;
      free = cyc;
      do_req(2'd2, 11'h155, 8'h23, 1'b1, acc);
      wr_req = 1'b0;

      for (int i = 0; i < 400 && exq.size() > 0; i++) @(negedge sclk);
      chk("drain_expected", 64'(exq.size()), 64'h0);
      chk("drain_fifo", 64'(fq.size()), 64'h0);
      repeat (3) @(negedge sclk);
      chk("idle_cmd", 64'(cmd_now()), 64'hF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
